// File: rtl/ram_pkg.sv
// ram_pkg: shared memory constants and controller state type.
package ram_pkg;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
endpackage

// File: rtl/ram_sync_clr_if.sv
// ram_sync_clr_if: access bus of the clearable synchronous RAM.
interface ram_sync_clr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] A;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              rw;
  logic              clr;
  logic              ready;
  logic [DATA_W-1:0] Q;
  logic              q_valid;
  modport master (output A, addr, en, rw, clr, input ready, Q, q_valid);
  modport slave  (input A, addr, en, rw, clr, output ready, Q, q_valid);
endinterface

// File: rtl/ram_clear_ctrl.sv
// ram_clear_ctrl: clear sequencer walking every word once after reset or on request.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // A request arriving mid-clear is ignored; the last word returns to idle.
  always_comb begin
    state_d = (state_q == S_CLEAR) ? (&cnt_q ? S_IDLE : S_CLEAR) : (clr ? S_CLEAR : S_IDLE);
    cnt_d   = (state_q == S_CLEAR) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ready    = (state_q == S_IDLE);
  assign clr_we   = (state_q == S_CLEAR);
  assign clr_addr = cnt_q;
endmodule

// File: rtl/ram_sync_clr.sv
// ram_sync_clr: single-port synchronous RAM with registered reads and hardware clear.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic           clk,
  input logic           rst,
  ram_sync_clr_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready, clr_we, acc, we;
  logic [ADDR_W-1:0] clr_addr, wa;
  logic [DATA_W-1:0] wd, q_q, q_d;
  logic              q_valid_q, q_valid_d;
  ram_clear_ctrl #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clr),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );
  // The clear engine owns the write port whenever it is running.
  always_comb begin
    acc       = ready & bus.en;
    we        = clr_we | (acc & (bus.rw == RW_WRITE));
    wa        = clr_we ? clr_addr : bus.addr;
    wd        = clr_we ? '0 : bus.A;
    q_valid_d = acc & (bus.rw == RW_READ);
    q_d       = q_valid_d ? mem[bus.addr] : q_q;
  end
  always_ff @(posedge clk) begin
    if (!rst && we) mem[wa] <= wd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end
  assign bus.ready   = ready;
  assign bus.Q       = q_q;
  assign bus.q_valid = q_valid_q;
endmodule

// File: tb/tb_ram_sync_clr.sv
// tb_ram_sync_clr: directed checks of the default and a generalised RAM build.
module tb_ram_sync_clr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ram_sync_clr_if #(.DATA_W(16), .ADDR_W(4)) b1 ();
  ram_sync_clr_if #(.DATA_W(32), .ADDR_W(6)) b2 ();

  ram_sync_clr #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  ram_sync_clr #(.DATA_W(32), .ADDR_W(6), .CLEAR_ON_RESET(0)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic en, input logic rw, input logic [3:0] addr, input logic [15:0] a, input logic clr);
    b1.en = en; b1.rw = rw; b1.addr = addr; b1.A = a; b1.clr = clr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (b1.Q !== 16'h0 || b1.q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: Q=%h q_valid=%b want Q=0000 q_valid=0", b1.Q, b1.q_valid);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (b1.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL poweron_ready_low[%0d]: ready=%b want 0", i, b1.ready);
      end
      step();
    end
    n_checks++;
    if (b1.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL poweron_ready_high: ready=%b want 1", b1.ready);
    end
    for (int i = 0; i < 16; i++) begin
      drv1(1'b1, 1'b1, 4'(i), 16'h0, 1'b0);
      step();
      n_checks++;
      if (b1.Q !== 16'h0000 || b1.q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL poweron_read[%0d]: Q=%h q_valid=%b want Q=0000 q_valid=1", i, b1.Q, b1.q_valid);
      end
    end
    drv1(1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
    step();
  endtask

  task automatic test_write_readback();
    logic [3:0]  ra [3];
    logic [15:0] rq [3];
    ra = '{4'd1, 4'd0, 4'd4};
    rq = '{16'hFFEE, 16'hABCD, 16'hEEEE};
    drv1(1'b1, 1'b0, 4'd0, 16'hABCD, 1'b0); step();
    drv1(1'b1, 1'b0, 4'd1, 16'hFFEE, 1'b0); step();
    drv1(1'b1, 1'b0, 4'd4, 16'hEEEE, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      drv1(1'b1, 1'b1, ra[i], 16'h0, 1'b0);
      step();
      n_checks++;
      if (b1.Q !== rq[i] || b1.q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL readback[%0d]: Q=%h q_valid=%b want Q=%h q_valid=1", i, b1.Q, b1.q_valid, rq[i]);
      end
    end
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step();
    n_checks++;
    if (b1.Q !== 16'hEEEE || b1.q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: Q=%h q_valid=%b want Q=eeee q_valid=0", b1.Q, b1.q_valid);
    end
  endtask

  task automatic test_write_then_read();
    drv1(1'b1, 1'b0, 4'd2, 16'h1357, 1'b0); step();
    drv1(1'b1, 1'b1, 4'd2, 16'h0, 1'b0); step();
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    n_checks++;
    if (b1.Q !== 16'h1357 || b1.q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_then_read: Q=%h q_valid=%b want Q=1357 q_valid=1", b1.Q, b1.q_valid);
    end
  endtask

  task automatic test_clear_request();
    logic [3:0] ra [2];
    ra = '{4'd3, 4'd0};
    drv1(1'b1, 1'b0, 4'd3, 16'h1234, 1'b1);
    step();
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (b1.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_ready_low[%0d]: ready=%b want 0", i, b1.ready);
      end
      step();
    end
    n_checks++;
    if (b1.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_ready_high: ready=%b want 1", b1.ready);
    end
    for (int i = 0; i < 2; i++) begin
      drv1(1'b1, 1'b1, ra[i], 16'h0, 1'b0);
      step();
      n_checks++;
      if (b1.Q !== 16'h0000 || b1.q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_read[%0d]: Q=%h q_valid=%b want Q=0000 q_valid=1", i, b1.Q, b1.q_valid);
      end
    end
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step();
  endtask

  task automatic test_clear_activity();
    int n;
    drv1(1'b1, 1'b0, 4'd5, 16'h2468, 1'b0); step();
    drv1(1'b1, 1'b1, 4'd5, 16'h0, 1'b1); step();
    n_checks++;
    if (b1.Q !== 16'h2468 || b1.q_valid !== 1'b1 || b1.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_with_read: Q=%h q_valid=%b ready=%b want Q=2468 q_valid=1 ready=0", b1.Q, b1.q_valid, b1.ready);
    end
    drv1(1'b1, 1'b0, 4'd7, 16'h5555, 1'b0); step();
    drv1(1'b1, 1'b1, 4'd7, 16'h0, 1'b0); step();
    n_checks++;
    if (b1.Q !== 16'h2468 || b1.q_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_during_clear: Q=%h q_valid=%b want Q=2468 q_valid=0", b1.Q, b1.q_valid);
    end
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b1); step();
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    n = 0;
    while (b1.ready !== 1'b1 && n < 40) begin step(); n++; end
    n_checks++;
    if (n !== 13) begin
      n_fail++;
      $display("FAIL clear_no_restart: edges_to_ready=%0d want 13", n);
    end
    drv1(1'b1, 1'b1, 4'd7, 16'h0, 1'b0); step();
    n_checks++;
    if (b1.Q !== 16'h0000 || b1.q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read7_after_clear: Q=%h q_valid=%b want Q=0000 q_valid=1", b1.Q, b1.q_valid);
    end
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b1); step();
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    n = 0;
    while (b1.ready !== 1'b1 && n < 40) begin step(); n++; end
    n_checks++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL rst_restarts_clear: edges_to_ready=%0d want 16", n);
    end
  endtask

  task automatic test_generalised();
    int n;
    b2.en = 1'b0; b2.rw = 1'b0; b2.addr = '0; b2.A = '0; b2.clr = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if (b2.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL gen_ready_after_reset: ready=%b want 1", b2.ready);
    end
    b2.en = 1'b1; b2.rw = 1'b0; b2.addr = 6'd63; b2.A = 32'hDEADBEEF; step();
    b2.rw = 1'b1; step();
    b2.en = 1'b0;
    n_checks++;
    if (b2.Q !== 32'hDEADBEEF || b2.q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gen_readback: Q=%h q_valid=%b want Q=deadbeef q_valid=1", b2.Q, b2.q_valid);
    end
    b2.clr = 1'b1; step(); b2.clr = 1'b0;
    n = 0;
    while (b2.ready !== 1'b1 && n < 100) begin step(); n++; end
    n_checks++;
    if (n !== 64) begin
      n_fail++;
      $display("FAIL gen_clear_len: edges_to_ready=%0d want 64", n);
    end
    b2.en = 1'b1; b2.rw = 1'b1; b2.addr = 6'd63; step();
    b2.en = 1'b0;
    n_checks++;
    if (b2.Q !== 32'h0 || b2.q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gen_read_after_clear: Q=%h q_valid=%b want Q=00000000 q_valid=1", b2.Q, b2.q_valid);
    end
  endtask

  initial begin
    drv1(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    b2.en = 1'b0; b2.rw = 1'b0; b2.addr = '0; b2.A = '0; b2.clr = 1'b0;
    #1;
    test_reset();
    test_write_readback();
    test_write_then_read();
    test_clear_request();
    test_clear_activity();
    test_generalised();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
